// File: rtl/cpu_inst_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
interface cpu_inst_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_pc;
   logic [31:0]      in_inst;
   logic             in_fault;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [31:0]      out_inst;
   logic             out_fault;
   logic [CNT_W-1:0] count;

   // Fetch/decode environment side
   modport master (
      output in_valid, in_pc, in_inst, in_fault, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_fault, count
   );

   // Queue side
   modport slave (
      input  in_valid, in_pc, in_inst, in_fault, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_fault, count
   );
endinterface

// File: rtl/cpu_inst_queue.sv
// Instruction queue: small FIFO of {pc, inst, fault} words between fetch and decode.
// All outputs come straight from flops; the head word is precomputed from next state.
module cpu_inst_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   cpu_inst_queue_if.slave   q
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } word_t;

   word_t            mem_q [DEPTH];
   word_t            mem_d [DEPTH];
   logic [PTR_W-1:0] rp_q, rp_d;
   logic [PTR_W-1:0] wp_q, wp_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   word_t            head_q, head_d;
   logic             push;
   logic             pop;

   // Next-state: pointers, occupancy, storage write and the next head word
   always_comb begin
      push        = q.in_valid & in_ready_q & ~flush;
      pop         = out_valid_q & q.out_ready & ~flush;
      mem_d       = mem_q;
      rp_d        = rp_q;
      wp_d        = wp_q;
      count_d     = count_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      head_d      = head_q;

      if (push) begin
         mem_d[wp_q] = '{pc: q.in_pc, inst: q.in_inst, fault: q.in_fault};
         wp_d        = wp_q + PTR_W'(1);
      end
      if (pop) begin
         rp_d = rp_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (flush) begin
         rp_d    = '0;
         wp_d    = '0;
         count_d = '0;
      end

      in_ready_d  = (count_d != CNT_W'(DEPTH));
      out_valid_d = (count_d != '0);
      // Reading mem_d covers a word written this cycle into the new head slot
      head_d      = out_valid_d ? mem_d[rp_d] : '0;
   end

   // Control and output registers; reset empties the queue
   always_ff @(posedge clk) begin
      if (rst) begin
         rp_q        <= '0;
         wp_q        <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         head_q      <= '0;
      end else begin
         rp_q        <= rp_d;
         wp_q        <= wp_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         head_q      <= head_d;
      end
   end

   // Storage array; contents are don't-care while not counted
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign q.in_ready  = in_ready_q;
   assign q.out_valid = out_valid_q;
   assign q.out_pc    = head_q.pc;
   assign q.out_inst  = head_q.inst;
   assign q.out_fault = head_q.fault;
   assign q.count     = count_q;
endmodule

// File: tb/tb_cpu_inst_queue.sv
// Directed bench for cpu_inst_queue: vector table plus streaming and wrap sequences.
module tb_cpu_inst_queue;
   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   checks = 0;
   int   errors = 0;

   cpu_inst_queue_if #(.DEPTH(4)) bus ();

   cpu_inst_queue #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .q     (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        flt;
      logic        ordy;
      int          e_cnt;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_flt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic flt, input logic ordy);
      flush        = fl;
      bus.in_valid = iv;
      bus.in_pc    = pc;
      bus.in_inst  = inst;
      bus.in_fault = flt;
      bus.out_ready = ordy;
   endtask

   task automatic chk_outs(input string tag, input int e_cnt, input logic e_ov, input logic e_ir,
                           input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_flt);
      chk({tag, " count"},     32'(bus.count),     32'(e_cnt));
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(e_ov));
      chk({tag, " in_ready"},  32'(bus.in_ready),  32'(e_ir));
      chk({tag, " out_pc"},    bus.out_pc,         e_pc);
      chk({tag, " out_inst"},  bus.out_inst,       e_inst);
      chk({tag, " out_fault"}, 32'(bus.out_fault), 32'(e_flt));
   endtask

   initial begin
      logic [31:0] sb[$];
      logic [31:0] pc_seq;
      logic [31:0] exp_pc;
      int          n;

      // fl iv pc inst flt ordy | cnt ov ir pc inst flt
      vecs.push_back('{0,0,32'h0,   32'h0,       0,0, 0,0,1,32'h0,   32'h0,       0});
      vecs.push_back('{0,1,32'h100, 32'hA100,    0,0, 1,1,1,32'h100, 32'hA100,    0});
      vecs.push_back('{0,1,32'h104, 32'hA104,    0,0, 2,1,1,32'h100, 32'hA100,    0});
      vecs.push_back('{0,1,32'h108, 32'hA108,    0,0, 3,1,1,32'h100, 32'hA100,    0});
      vecs.push_back('{0,1,32'h10C, 32'hA10C,    0,0, 4,1,0,32'h100, 32'hA100,    0});
      vecs.push_back('{0,1,32'h110, 32'hA110,    0,0, 4,1,0,32'h100, 32'hA100,    0});
      vecs.push_back('{0,1,32'h110, 32'hA110,    0,1, 3,1,1,32'h104, 32'hA104,    0});
      vecs.push_back('{0,1,32'h110, 32'hA110,    0,1, 3,1,1,32'h108, 32'hA108,    0});
      vecs.push_back('{0,0,32'h0,   32'h0,       0,1, 2,1,1,32'h10C, 32'hA10C,    0});
      vecs.push_back('{1,1,32'h200, 32'hA200,    0,1, 0,0,1,32'h0,   32'h0,       0});
      vecs.push_back('{0,1,32'h400, 32'h8C220004,0,0, 1,1,1,32'h400, 32'h8C220004,0});
      vecs.push_back('{0,1,32'h1002,32'h24010001,1,1, 1,1,1,32'h1002,32'h24010001,1});
      vecs.push_back('{0,1,32'h1006,32'h24020002,0,1, 1,1,1,32'h1006,32'h24020002,0});
      vecs.push_back('{0,0,32'h0,   32'h0,       0,1, 0,0,1,32'h0,   32'h0,       0});
      vecs.push_back('{0,0,32'h0,   32'h0,       0,1, 0,0,1,32'h0,   32'h0,       0});
      vecs.push_back('{0,1,32'h500, 32'hA500,    0,0, 1,1,1,32'h500, 32'hA500,    0});
      vecs.push_back('{0,1,32'h504, 32'hA504,    0,0, 2,1,1,32'h500, 32'hA500,    0});
      vecs.push_back('{0,1,32'h508, 32'hA508,    0,0, 3,1,1,32'h500, 32'hA500,    0});
      vecs.push_back('{1,1,32'h50C, 32'hA50C,    0,1, 0,0,1,32'h0,   32'h0,       0});
      vecs.push_back('{0,0,32'h0,   32'h0,       0,0, 0,0,1,32'h0,   32'h0,       0});
      vecs.push_back('{0,1,32'h600, 32'hA600,    0,0, 1,1,1,32'h600, 32'hA600,    0});

      // Reset, with a word offered during reset that must be lost
      rst = 1'b1;
      drive(0, 1, 32'hDEAD, 32'hBEEF, 1, 1);
      tick();
      tick();
      rst = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 0, 0);
      chk_outs("reset", 0, 0, 1, 32'h0, 32'h0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].flt, vecs[i].ordy);
         tick();
         chk_outs($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ov, vecs[i].e_ir,
                  vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_flt);
      end

      // Drain the leftover word
      drive(0, 0, 32'h0, 32'h0, 0, 1);
      tick();
      chk_outs("drain", 0, 0, 1, 32'h0, 32'h0, 0);

      // Streaming: both sides ready, occupancy stays at one
      for (int i = 0; i < 20; i++) begin
         exp_pc = 32'h2000 + 32'(4 * i);
         drive(0, 1, exp_pc, exp_pc ^ 32'h5A5A0000, 0, 1);
         tick();
         chk_outs($sformatf("stream%0d", i), 1, 1, 1, exp_pc, exp_pc ^ 32'h5A5A0000, 0);
      end
      drive(0, 0, 32'h0, 32'h0, 0, 1);
      tick();
      chk_outs("stream_end", 0, 0, 1, 32'h0, 32'h0, 0);

      // Wrap-around: top up to 3, drain 2, ten rounds
      pc_seq = 32'h3000;
      n      = 0;
      for (int r = 0; r < 10; r++) begin
         while (n < 3) begin
            drive(0, 1, pc_seq, pc_seq ^ 32'h5A5A0000, pc_seq[2], 0);
            sb.push_back(pc_seq);
            pc_seq = pc_seq + 32'h4;
            n++;
            tick();
         end
         chk($sformatf("wrap%0d count", r), 32'(bus.count), 32'd3);
         for (int k = 0; k < 2; k++) begin
            exp_pc = sb.pop_front();
            chk($sformatf("wrap%0d.%0d out_valid", r, k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("wrap%0d.%0d out_pc", r, k), bus.out_pc, exp_pc);
            chk($sformatf("wrap%0d.%0d out_inst", r, k), bus.out_inst, exp_pc ^ 32'h5A5A0000);
            chk($sformatf("wrap%0d.%0d out_fault", r, k), 32'(bus.out_fault), 32'(exp_pc[2]));
            drive(0, 0, 32'h0, 32'h0, 0, 1);
            tick();
            n--;
         end
      end
      exp_pc = sb.pop_front();
      chk("wrap_last out_pc", bus.out_pc, exp_pc);
      drive(0, 0, 32'h0, 32'h0, 0, 1);
      tick();
      chk_outs("wrap_end", 0, 0, 1, 32'h0, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_inst_queue.md
# cpu_inst_queue

Instruction queue between the fetch stage and the combinational decoder. It buffers fetched `{pc, inst, fault}` words in a small synchronous FIFO and presents the oldest one to decode with a valid/ready handshake. It discards all buffered words on a pipeline redirect. When empty, it drives an all-zero instruction word, so the decoder sees `sll $0,$0,0` and classifies it as a nop.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥2
- `CNT_W`, log2(DEPTH)+1, width of `count`; derived, not overridden
- `clk`  input  1  rising-edge clock; the only clock
- `rst`  input  1  synchronous, active-high reset
- `flush`  input  1  redirect; drops every entry and any same-cycle push/pop
- `in_valid`  input  1  fetch offers a word
- `in_ready`  output  1  queue accepts a word this cycle
- `in_pc`  input  32  PC of offered word
- `in_inst`  input  32  instruction word
- `in_fault`  input  1  fetch address/bus error for this word
- `out_valid`  output  1  head entry valid
- `out_ready`  input  1  decode consumes the head this cycle
- `out_pc`  output  32  head PC; 0 when empty
- `out_inst`  output  32  head instruction; 0 when empty
- `out_fault`  output  1  head fault flag; 0 when empty
- `count`  output  CNT_W  number of stored entries, 0..DEPTH

## Operation
- Storage: DEPTH-entry array with read pointer `rp`, write pointer `wp` and occupancy `count`. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `push = in_valid & in_ready & ~flush`; `pop = out_valid & out_ready & ~flush`.
- `in_ready = (count != DEPTH)`. It is a function of registered state only and does not depend on `out_ready`. When the queue is full, a same-cycle pop does not free a slot for a push.
- `out_valid = (count != 0)`. `out_pc`, `out_inst` and `out_fault` read `mem[rp]` when valid and are forced to 0 when empty.
- On push: write `{in_pc, in_inst, in_fault}` to `mem[wp]` and increment `wp`.
- On pop: increment `rp`.
- `count` update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- There is no combinational path from input to output. A word pushed into an empty queue appears at the output on the next cycle.
- `flush` has priority over everything else: `rp = wp = 0`, `count = 0`, and any push or pop in that cycle is ignored. The array contents need not be cleared.
- `rst` behaves the same as `flush` and has priority over it.
- Fault words are queued like any other word. The queue never interprets `inst`.
- The queue never reorders, drops or duplicates words except on flush or reset.

## Timing
- Reset values, effective from the cycle after `rst` is sampled high:
  - `count = 0`, `out_valid = 0`, `out_pc = 0`, `out_inst = 0`, `out_fault = 0`, `in_ready = 1`
- Pushes presented in the reset cycle are lost.
- Latency from push to `out_valid`: 1 cycle, when the queue is empty.
- Throughput: 1 word/cycle sustained when `count` is between 1 and DEPTH-1 and both sides are ready.
- Full queue (`count = DEPTH`): `in_ready = 0`. A pop that cycle brings `count` to DEPTH-1, and `in_ready` rises on the next cycle.
- Empty queue: an `out_ready` asserted with `out_valid = 0` has no effect.
- Flush at cycle N: outputs are empty and `in_ready = 1` from cycle N+1. A word offered in cycle N+1 is accepted normally.
- Handshake rule: fetch must hold `in_*` stable while `in_valid & ~in_ready`. Decode may change `out_ready` freely.

## Test plan
- Reset then fill: push PCs 0x100, 0x104, 0x108, 0x10C with `out_ready = 0` → `count` goes 1..4, `in_ready = 0` after the 4th push, `out_pc = 0x100`, and a 5th word offered is held off.
- Empty output: after reset, `out_valid = 0`, `out_inst = 0x00000000`, `out_pc = 0`. Push inst 0x8C220004 at PC 0x400 → the next cycle shows `out_valid = 1` and `out_inst = 0x8C220004`.
- Streaming: both sides always ready for 20 words with PCs incrementing by 4 → output order matches, and `count` stays at 1 after the first cycle.
- Wrap-around: fill 3, drain 2, and repeat for 10 rounds with DEPTH = 4 → pointers wrap and no data is corrupted.
- Flush with simultaneous push and pop at `count = 3` → next cycle `count = 0`, `out_valid = 0`, and the pushed word never appears.
- Fault propagation: push PC 0x1002 with `in_fault = 1` → it pops with `out_fault = 1`, and neighbouring entries show `out_fault = 0`.
